sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of requesters (0=P1, 1=P2, 2=Money, 3=Car); the arbiter SHALL support only this value.
REQ-002 Parameter ADDR_W, 16, sprite ROM address width.
REQ-003 Parameter DATA_W, 6, palette index width.
REQ-004 Parameter ROM_LAT, 2, ROM read latency in clocks, legal range 1..4.
REQ-005 Clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Hold  in  1  when high, no new grants are issued.
REQ-008 Req  in  NREQ  per-requester read request, level.
REQ-009 ReqAddr  in  NREQ*ADDR_W  request addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 Gnt  out  NREQ  one-hot grant pulse, one clock wide.
REQ-011 RomEn  out  1  ROM read strobe.
REQ-012 RomAddr  out  ADDR_W  ROM read address.
REQ-013 RomData  in  DATA_W  ROM read data, valid ROM_LAT clocks after RomEn.
REQ-014 RspValid  out  NREQ  one-hot response-valid pulse.
REQ-015 RspData  out  DATA_W  palette index returned to the requester flagged by RspValid.

Function
REQ-016 Gnt, RomEn and RomAddr SHALL be registered; a grant decided from Req/ReqAddr sampled at edge N SHALL appear on the outputs during cycle N+1.
REQ-017 At most one Gnt bit SHALL be high per cycle, and RomEn SHALL equal |Gnt.
REQ-018 RomAddr SHALL equal ReqAddr of the granted requester, sampled at the deciding edge; it SHALL hold its last value while RomEn is low.
REQ-019 Handshake: a requester SHALL hold Req and ReqAddr stable until it sees Gnt; Req sampled high in the cycle Gnt is high counts as a new request.
REQ-020 Arbitration SHALL be round-robin: a last-grant pointer LP (2 bits) is kept, and the search starts at LP+1 mod 4, taking the first requester with Req high.
REQ-021 LP SHALL update to the granted index only on a grant cycle and SHALL be unchanged otherwise.
REQ-022 Throughput SHALL be one grant per clock; a lone requester holding Req SHALL be granted every cycle.
REQ-023 While Hold is high, Gnt and RomEn SHALL be 0 and LP unchanged; in-flight responses SHALL still complete; grants SHALL resume in the cycle after Hold falls.
REQ-024 A response pipeline of depth ROM_LAT SHALL carry {valid, one-hot id}; RspValid SHALL be the id from ROM_LAT clocks after the matching RomEn, and RspData SHALL be RomData in that cycle.
REQ-025 RspData SHALL hold its last value when RspValid is 0.
REQ-026 Responses SHALL return in grant order; back-to-back grants SHALL yield back-to-back responses with no bubbles or reordering.
REQ-027 Req high with all bits 0 SHALL NOT occur; with Req=0 no grant is issued and LP is unchanged.

Reset
REQ-028 While Reset is high: Gnt=0, RomEn=0, RomAddr=0, RspValid=0, RspData=0, LP=3 (so the first search order is 0,1,2,3), and the response pipeline SHALL be cleared.
REQ-029 A reset asserted mid-operation SHALL discard every in-flight response: no RspValid is issued for grants made before the reset.
REQ-030 No grant SHALL be decided from Req sampled in a cycle where Reset is high; the first possible Gnt is in the 2nd cycle after Reset falls.

Verification
REQ-031 After reset, Req=4'b1111 held for 4 cycles → Gnt sequence 0001, 0010, 0100, 1000; with ROM_LAT=2, RspValid repeats the same sequence starting 2 cycles later.
REQ-032 Req=4'b0100, ReqAddr[2]=16'h01A3, ROM returns 6'h2C → RomAddr=16'h01A3 with RomEn high for one cycle, then 2 cycles later RspValid=4'b0100 and RspData=6'h2C.
REQ-033 LP=1 with Req=4'b0011 → Gnt=0001 (wrap past 3 to 0), then Gnt=0010.
REQ-034 Req=4'b1000 held while Hold rises for 3 cycles → Gnt=0 for those 3 cycles, then Gnt=1000 in the cycle after Hold falls; a response already in flight when Hold rises still arrives on time.
REQ-035 Three back-to-back grants, then Reset pulsed one cycle after the third RomEn → no RspValid for any of them, LP=3, all outputs 0.
REQ-036 Random Req/Hold for 10k cycles, checked against a scoreboard → the one-hot rules hold, no requester waits more than 4 grant cycles, and every response is exact and in order.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM among four requesters.
// Registered grants feed a ROM_LAT-deep tag pipeline that steers returning data back to its requester.
module sprite_rom_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 6,
    parameter int ROM_LAT = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Hold,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ*ADDR_W-1:0]   ReqAddr,
    output logic [NREQ-1:0]          Gnt,
    output logic                     RomEn,
    output logic [ADDR_W-1:0]        RomAddr,
    input  logic [DATA_W-1:0]        RomData,
    output logic [NREQ-1:0]          RspValid,
    output logic [DATA_W-1:0]        RspData
);

    localparam int LP_W = $clog2(NREQ);

    logic [LP_W-1:0]   lp_q, lp_d;
    logic [LP_W-1:0]   idx;
    logic              found;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_vld;

    logic              pipe_vld_q [ROM_LAT];
    logic              pipe_vld_d [ROM_LAT];
    logic [NREQ-1:0]   pipe_id_q  [ROM_LAT];
    logic [NREQ-1:0]   pipe_id_d  [ROM_LAT];

    // Search starts one past the last winner so every requester is reached within NREQ grants.
    always_comb begin
        gnt_d      = '0;
        lp_d       = lp_q;
        rom_addr_d = rom_addr_q;
        found      = 1'b0;
        idx        = '0;
        if (!Hold) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = lp_q + LP_W'(k);
                if (!found && Req[idx]) begin
                    found      = 1'b1;
                    gnt_d[idx] = 1'b1;
                    lp_d       = idx;
                    rom_addr_d = ReqAddr[idx*ADDR_W +: ADDR_W];
                end
            end
        end
        rom_en_d = found;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            gnt_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            lp_q       <= LP_W'(NREQ - 1);
            rsp_data_q <= '0;
        end else begin
            gnt_q      <= gnt_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            lp_q       <= lp_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROM_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pipe_vld_d[gi] = rom_en_q;
                assign pipe_id_d[gi]  = gnt_q;
            end else begin : g_tail
                assign pipe_vld_d[gi] = pipe_vld_q[gi-1];
                assign pipe_id_d[gi]  = pipe_id_q[gi-1];
            end

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    pipe_vld_q[gi] <= 1'b0;
                    pipe_id_q[gi]  <= '0;
                end else begin
                    pipe_vld_q[gi] <= pipe_vld_d[gi];
                    pipe_id_q[gi]  <= pipe_id_d[gi];
                end
            end
        end
    endgenerate

    // Reset masks the pipeline tail immediately so a response due in a reset cycle never escapes.
    assign rsp_vld    = pipe_vld_q[ROM_LAT-1] & ~Reset;
    assign rsp_data_d = rsp_vld ? RomData : rsp_data_q;

    assign Gnt      = gnt_q;
    assign RomEn    = rom_en_q;
    assign RomAddr  = rom_addr_q;
    assign RspValid = {NREQ{rsp_vld}} & pipe_id_q[ROM_LAT-1];
    assign RspData  = Reset ? '0 : rsp_data_d;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed vectors with literal expectations plus a
// queue-based reference model compared against the outputs every cycle.
module tb_sprite_rom_arbiter;

    localparam int ROM_LAT = 2;

    logic        Clk;
    logic        Reset;
    logic        Hold;
    logic [3:0]  Req;
    logic [63:0] ReqAddr;
    logic [3:0]  Gnt;
    logic        RomEn;
    logic [15:0] RomAddr;
    logic [5:0]  RomData;
    logic [3:0]  RspValid;
    logic [5:0]  RspData;

    sprite_rom_arbiter #(
        .NREQ(4), .ADDR_W(16), .DATA_W(6), .ROM_LAT(ROM_LAT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Hold(Hold), .Req(Req), .ReqAddr(ReqAddr),
        .Gnt(Gnt), .RomEn(RomEn), .RomAddr(RomAddr), .RomData(RomData),
        .RspValid(RspValid), .RspData(RspData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ROM contents; one known entry is pinned for the directed address test.
    function automatic logic [5:0] rom_f(input logic [15:0] a);
        if (a == 16'h01A3) return 6'h2C;
        return a[5:0] ^ a[11:6] ^ {a[15:12], 2'b01};
    endfunction

    // ROM with two-cycle read latency; non-enabled slots carry junk.
    logic [5:0] rom_p1, rom_p2;
    always @(posedge Clk) begin
        rom_p1 <= RomEn ? rom_f(RomAddr) : 6'h3F;
        rom_p2 <= rom_p1;
    end
    assign RomData = rom_p2;

    // Reference model: round-robin pointer plus a queue of responses with due cycles.
    typedef struct {
        int         due;
        logic [3:0] id;
        logic [5:0] data;
    } rsp_t;

    rsp_t        q[$];
    int          cyc = 0;
    int          lp_m = 3;
    logic [3:0]  exp_gnt = '0;
    logic [15:0] exp_addr = '0;
    logic [5:0]  exp_hold = '0;

    always @(posedge Clk) begin
        cyc++;
        if (Reset) begin
            lp_m     = 3;
            exp_gnt  = '0;
            exp_addr = '0;
            exp_hold = '0;
            q.delete();
        end else begin
            exp_gnt = '0;
            if (!Hold) begin
                for (int k = 1; k <= 4; k++) begin
                    int i;
                    i = (lp_m + k) % 4;
                    if (Req[i]) begin
                        exp_gnt  = 4'(1 << i);
                        exp_addr = ReqAddr[i*16 +: 16];
                        lp_m     = i;
                        q.push_back('{cyc + ROM_LAT, exp_gnt, rom_f(exp_addr)});
                        break;
                    end
                end
            end
        end
    end

    always @(negedge Clk) begin
        logic [3:0] exp_rv;
        logic [5:0] exp_rd;
        if (cyc >= 1) begin
            exp_rv = '0;
            exp_rd = exp_hold;
            if (Reset) begin
                exp_rd = '0;
                while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
            end else if (q.size() > 0 && q[0].due == cyc) begin
                exp_rv   = q[0].id;
                exp_rd   = q[0].data;
                exp_hold = q[0].data;
                void'(q.pop_front());
            end
            chk("m_gnt", 32'(Gnt), 32'(exp_gnt));
            chk("m_romen", 32'(RomEn), 32'(exp_gnt != 0));
            chk("m_romaddr", 32'(RomAddr), 32'(exp_addr));
            chk("m_rspvalid", 32'(RspValid), 32'(exp_rv));
            chk("m_rspdata", 32'(RspData), 32'(exp_rd));
            chk("gnt_onehot", 32'($countones(Gnt) <= 1), 32'd1);
            chk("rsp_onehot", 32'($countones(RspValid) <= 1), 32'd1);
        end
    end

    task automatic step(input logic [3:0] r, input logic h, input logic rs);
        Req   = r;
        Hold  = h;
        Reset = rs;
        @(posedge Clk);
        #2;
    endtask

    logic [3:0]  g_seq [4];
    logic [3:0]  rq, prev_rq;
    logic [15:0] ra [4];
    logic        h_r, rs_r;
    int          wait_cnt [4];
    int          max_wait;

    initial begin
        Reset   = 1'b1;
        Hold    = 1'b0;
        Req     = '0;
        ReqAddr = {16'h4444, 16'h01A3, 16'h2222, 16'h1111};
        g_seq[0] = 4'b0001; g_seq[1] = 4'b0010; g_seq[2] = 4'b0100; g_seq[3] = 4'b1000;

        // Reset state
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk("rst_gnt", 32'(Gnt), 0);
        chk("rst_romen", 32'(RomEn), 0);
        chk("rst_romaddr", 32'(RomAddr), 0);
        chk("rst_rspvalid", 32'(RspValid), 0);
        chk("rst_rspdata", 32'(RspData), 0);

        // Requests sampled during reset are ignored
        step(4'b1111, 1'b0, 1'b1);
        chk("no_gnt_in_reset", 32'(Gnt), 0);

        // All requesting: grants rotate 0,1,2,3 and responses follow two cycles later
        for (int i = 0; i < 6; i++) begin
            step((i < 4) ? 4'b1111 : 4'b0000, 1'b0, 1'b0);
            if (i < 4) chk("rr_gnt", 32'(Gnt), 32'(g_seq[i]));
            if (i == 2) chk("rr_addr2", 32'(RomAddr), 32'h01A3);
            if (i >= 2) chk("rr_rsp", 32'(RspValid), 32'(g_seq[i-2]));
            if (i == 4) chk("rr_data2", 32'(RspData), 32'h2C);
        end
        step(4'b0000, 1'b0, 1'b0);

        // Single request from Money
        step(4'b0100, 1'b0, 1'b0);
        chk("money_gnt", 32'(Gnt), 32'b0100);
        chk("money_romen", 32'(RomEn), 1);
        chk("money_addr", 32'(RomAddr), 32'h01A3);
        step(4'b0000, 1'b0, 1'b0);
        chk("money_romen_low", 32'(RomEn), 0);
        chk("money_addr_hold", 32'(RomAddr), 32'h01A3);
        step(4'b0000, 1'b0, 1'b0);
        chk("money_rsp", 32'(RspValid), 32'b0100);
        chk("money_data", 32'(RspData), 32'h2C);
        step(4'b0000, 1'b0, 1'b0);
        chk("money_rsp_off", 32'(RspValid), 0);
        chk("money_data_hold", 32'(RspData), 32'h2C);

        // Pointer wrap: grant P2 to set LP=1, then 0011 gives 0001 then 0010
        step(4'b0010, 1'b0, 1'b0);
        chk("wrap_setup", 32'(Gnt), 32'b0010);
        step(4'b0011, 1'b0, 1'b0);
        chk("wrap_gnt0", 32'(Gnt), 32'b0001);
        step(4'b0011, 1'b0, 1'b0);
        chk("wrap_gnt1", 32'(Gnt), 32'b0010);
        step(4'b0000, 1'b0, 1'b0);

        // Hold: in-flight response completes, grants resume after release
        step(4'b1000, 1'b0, 1'b0);
        chk("hold_pre", 32'(Gnt), 32'b1000);
        step(4'b1000, 1'b1, 1'b0);
        chk("hold_gnt1", 32'(Gnt), 0);
        step(4'b1000, 1'b1, 1'b0);
        chk("hold_gnt2", 32'(Gnt), 0);
        chk("hold_inflight", 32'(RspValid), 32'b1000);
        step(4'b1000, 1'b1, 1'b0);
        chk("hold_gnt3", 32'(Gnt), 0);
        chk("hold_romen3", 32'(RomEn), 0);
        step(4'b1000, 1'b0, 1'b0);
        chk("hold_resume", 32'(Gnt), 32'b1000);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Three back-to-back grants, then reset discards every in-flight response
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0, 1'b0);
            chk("b2b_gnt", 32'(Gnt), 32'(g_seq[i]));
            chk("b2b_romen", 32'(RomEn), 1);
        end
        Req   = 4'b0000;
        Reset = 1'b1;
        #1;
        chk("rst_mid_rsp", 32'(RspValid), 0);
        chk("rst_mid_data", 32'(RspData), 0);
        @(posedge Clk);
        #2;
        chk("rst_mid_gnt", 32'(Gnt), 0);
        chk("rst_mid_romen", 32'(RomEn), 0);
        chk("rst_mid_addr", 32'(RomAddr), 0);
        step(4'b0000, 1'b0, 1'b0);
        chk("rst_drop1", 32'(RspValid), 0);
        step(4'b0000, 1'b0, 1'b0);
        chk("rst_drop2", 32'(RspValid), 0);
        chk("rst_data0", 32'(RspData), 0);
        step(4'b1111, 1'b0, 1'b0);
        chk("rst_lp3", 32'(Gnt), 32'b0001);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Randomised traffic with requesters honouring the hold-until-grant handshake
        rq       = '0;
        max_wait = 0;
        for (int i = 0; i < 4; i++) begin
            wait_cnt[i] = 0;
            ra[i]       = 16'($urandom);
        end
        for (int n = 0; n < 10000; n++) begin
            h_r  = ($urandom_range(0, 7) == 0);
            rs_r = ($urandom_range(0, 1499) == 0);
            ReqAddr = {ra[3], ra[2], ra[1], ra[0]};
            prev_rq = rq;
            step(rq, h_r, rs_r);
            if (rs_r) begin
                rq = '0;
                for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
            end else begin
                if (Gnt != 4'b0000) begin
                    for (int i = 0; i < 4; i++) begin
                        if (Gnt[i]) wait_cnt[i] = 0;
                        else if (prev_rq[i]) begin
                            wait_cnt[i]++;
                            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                        end
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (!rq[i] || Gnt[i]) begin
                        rq[i] = ($urandom_range(0, 2) != 0);
                        ra[i] = 16'($urandom);
                    end
                end
            end
        end
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 1'b0);
        chk("drain_empty", 32'(q.size()), 0);
        chk("fair_wait", 32'(max_wait <= 4), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
